// File: rtl/pos_pkg.sv
// Shared types for the 8.8 fixed-point position interpolator: FSM states,
// position word and the grid-to-position conversion.
package pos_pkg;

    localparam int FRAC_BITS = 8;
    localparam int POS_W     = 16;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Integer grid coordinate to 8.8 position (fraction zeroed).
    function automatic pos_t grid_to_pos(input logic [7:0] g);
        return pos_t'(g) << FRAC_BITS;
    endfunction

endpackage

// File: rtl/axis_step.sv
// One axis of the interpolator: next position one STEP toward the target,
// clamped onto the target when within reach so it never overshoots or wraps.
module axis_step
    import pos_pkg::*;
#(
    parameter logic [15:0] STEP = 16'h0040
) (
    input  pos_t pos,
    input  pos_t tgt,
    output pos_t next_pos,
    output logic at_tgt
);

    logic signed [16:0] diff;
    logic        [16:0] mag;

    always_comb begin
        diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});
        mag  = diff[16] ? 17'(-diff) : 17'(diff);
        if (mag <= {1'b0, STEP}) begin
            next_pos = tgt;
        end else if (diff[16]) begin
            next_pos = pos - STEP;
        end else begin
            next_pos = pos + STEP;
        end
        at_tgt = (next_pos == tgt);
    end

endmodule

// File: rtl/pos_interp.sv
// Position interpolator: accepts a grid target and walks x/y toward it by
// STEP per frame tick, pulsing pos_valid_out per update and done_out on arrival.
module pos_interp
    import pos_pkg::*;
#(
    parameter logic [15:0] STEP = 16'h0040
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [7:0]  x_tgt_in,
    input  logic [7:0]  y_tgt_in,
    input  logic        tick_in,
    output logic [15:0] x_out,
    output logic [15:0] y_out,
    output logic        pos_valid_out,
    output logic        busy_out,
    output logic        done_out
);

    if (STEP == 16'h0000) begin : g_step_check
        $error("pos_interp: STEP must be nonzero");
    end

    state_t     state_reg, state_next;
    pos_t       pos_reg  [2];
    pos_t       pos_next [2];
    pos_t       tgt_reg  [2];
    pos_t       tgt_next [2];
    pos_t       cmd_tgt  [2];
    pos_t       step_pos [2];
    logic [1:0] at_tgt;
    logic       pos_valid_reg, pos_valid_next;

    assign cmd_tgt[0] = grid_to_pos(x_tgt_in);
    assign cmd_tgt[1] = grid_to_pos(y_tgt_in);

    // Index 0 is x, index 1 is y.
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        axis_step #(.STEP(STEP)) u_axis_step (
            .pos      (pos_reg[gi]),
            .tgt      (tgt_reg[gi]),
            .next_pos (step_pos[gi]),
            .at_tgt   (at_tgt[gi])
        );
    end

    always_comb begin
        state_next     = state_reg;
        pos_next       = pos_reg;
        tgt_next       = tgt_reg;
        pos_valid_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A tick arriving with the command is deliberately dropped.
                if (cmd_valid_in) begin
                    tgt_next   = cmd_tgt;
                    state_next = (cmd_tgt[0] == pos_reg[0] && cmd_tgt[1] == pos_reg[1])
                                 ? ST_DONE : ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (tick_in) begin
                    pos_next       = step_pos;
                    pos_valid_next = 1'b1;
                    if (&at_tgt) state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg     <= ST_IDLE;
            pos_valid_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pos_reg[i] <= '0;
                tgt_reg[i] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            pos_valid_reg <= pos_valid_next;
            pos_reg       <= pos_next;
            tgt_reg       <= tgt_next;
        end
    end

    assign x_out         = pos_reg[0];
    assign y_out         = pos_reg[1];
    assign pos_valid_out = pos_valid_reg;
    assign cmd_ready_out = (state_reg == ST_IDLE);
    assign busy_out      = (state_reg == ST_MOVE);
    assign done_out      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_pos_interp.sv
// Randomized bench for pos_interp: three instances (STEP 0040, 0060, FF00)
// checked cycle by cycle against a per-axis arithmetic trajectory model.
module tb_pos_interp;

    localparam int          N     = 3;
    localparam logic [47:0] STEPS = {16'hFF00, 16'h0060, 16'h0040};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid [N];
    logic [7:0]  xt        [N];
    logic [7:0]  yt        [N];
    logic        tick      [N];
    logic        ready     [N];
    logic        pv        [N];
    logic        busy      [N];
    logic        done      [N];
    logic [15:0] xo        [N];
    logic [15:0] yo        [N];

    int mx [N];
    int my [N];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        pos_interp #(.STEP(STEPS[gi*16 +: 16])) u_dut (
            .clk_in        (clk),
            .rst_n_in      (rst_n),
            .cmd_valid_in  (cmd_valid[gi]),
            .cmd_ready_out (ready[gi]),
            .x_tgt_in      (xt[gi]),
            .y_tgt_in      (yt[gi]),
            .tick_in       (tick[gi]),
            .x_out         (xo[gi]),
            .y_out         (yo[gi]),
            .pos_valid_out (pv[gi]),
            .busy_out      (busy[gi]),
            .done_out      (done[gi])
        );
    end

    function automatic int step_of(input int k);
        logic [47:0] v;
        v = STEPS;
        return int'(v[k*16 +: 16]);
    endfunction

    // One tick on one axis: land on the target if within one step, else move one step toward it.
    function automatic int step_axis(input int p, input int t, input int s);
        int d;
        d = t - p;
        if ((d < 0 ? -d : d) <= s) return t;
        return (d > 0) ? p + s : p - s;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_reset();
        for (int k = 0; k < N; k++) begin
            mx[k] = 0;
            my[k] = 0;
            chk("rst_x", k, xo[k], 0);
            chk("rst_y", k, yo[k], 0);
            chk("rst_ready", k, ready[k], 1);
            chk("rst_busy", k, busy[k], 0);
            chk("rst_done", k, done[k], 0);
            chk("rst_pv", k, pv[k], 0);
        end
    endtask

    task automatic move(input int k, input logic [7:0] x, input logic [7:0] y, input int abort_after);
        int tx, ty, s, ticks, need, dx, dy;
        bit t, reached;
        tx = int'(x) * 256;
        ty = int'(y) * 256;
        s  = step_of(k);
        // Tick while idle must not move anything.
        tick[k] = 1'b1;
        cmd_valid[k] = 1'b0;
        @(negedge clk);
        chk("idle_x", k, xo[k], mx[k]);
        chk("idle_pv", k, pv[k], 0);
        chk("idle_ready", k, ready[k], 1);
        cmd_valid[k] = 1'b1;
        xt[k] = x;
        yt[k] = y;
        tick[k] = 1'($urandom % 2);
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        tick[k] = 1'b0;
        if (tx == mx[k] && ty == my[k]) begin
            chk("same_done", k, done[k], 1);
            chk("same_pv", k, pv[k], 0);
            chk("same_busy", k, busy[k], 0);
            chk("same_x", k, xo[k], mx[k]);
            @(negedge clk);
            chk("same_done_end", k, done[k], 0);
            chk("same_ready", k, ready[k], 1);
            $display("dut%0d move (%0h,%0h) already there", k, x, y);
            return;
        end
        chk("acc_busy", k, busy[k], 1);
        chk("acc_ready", k, ready[k], 0);
        chk("acc_pv", k, pv[k], 0);
        chk("acc_x", k, xo[k], mx[k]);
        chk("acc_y", k, yo[k], my[k]);
        dx = (tx > mx[k]) ? tx - mx[k] : mx[k] - tx;
        dy = (ty > my[k]) ? ty - my[k] : my[k] - ty;
        need = ((dx > dy ? dx : dy) + s - 1) / s;
        ticks = 0;
        reached = 1'b0;
        for (int c = 0; c < 4096 && !reached; c++) begin
            t = ($urandom % 4) != 0;
            tick[k] = t;
            cmd_valid[k] = 1'($urandom % 2);
            xt[k] = 8'($urandom);
            yt[k] = 8'($urandom);
            @(negedge clk);
            if (t) begin
                ticks++;
                mx[k] = step_axis(mx[k], tx, s);
                my[k] = step_axis(my[k], ty, s);
                chk("x", k, xo[k], mx[k]);
                chk("y", k, yo[k], my[k]);
                chk("pv", k, pv[k], 1);
                reached = (mx[k] == tx && my[k] == ty);
                chk("done", k, done[k], reached);
                chk("busy", k, busy[k], !reached);
                if (!reached && abort_after != 0 && ticks == abort_after) begin
                    tick[k] = 1'b0;
                    cmd_valid[k] = 1'b0;
                    $display("dut%0d move (%0h,%0h) stopped after %0d ticks", k, x, y, ticks);
                    return;
                end
            end else begin
                chk("hold_pv", k, pv[k], 0);
                chk("hold_x", k, xo[k], mx[k]);
                chk("hold_busy", k, busy[k], 1);
            end
        end
        if (!reached) begin
            chk("timeout", k, 0, 1);
            tick[k] = 1'b0;
            cmd_valid[k] = 1'b0;
            return;
        end
        chk("latency", k, ticks, need);
        tick[k] = 1'($urandom % 2);
        cmd_valid[k] = 1'($urandom % 2);
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        tick[k] = 1'b0;
        chk("end_done", k, done[k], 0);
        chk("end_ready", k, ready[k], 1);
        chk("end_busy", k, busy[k], 0);
        chk("end_pv", k, pv[k], 0);
        chk("end_x", k, xo[k], mx[k]);
        chk("end_y", k, yo[k], my[k]);
        $display("dut%0d move (%0h,%0h) done in %0d ticks pos=%0h,%0h", k, x, y, ticks, xo[k], yo[k]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            cmd_valid[k] = 1'b0;
            tick[k] = 1'b0;
            xt[k] = 8'h00;
            yt[k] = 8'h00;
            mx[k] = 0;
            my[k] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        move(0, 8'h03, 8'h00, 0);
        move(1, 8'h03, 8'h00, 0);
        move(1, 8'h01, 8'h02, 0);
        move(0, 8'h05, 8'h05, 0);
        move(0, 8'h05, 8'h05, 0);
        move(2, 8'hFF, 8'hFF, 0);
        move(2, 8'h00, 8'h00, 0);

        for (int i = 0; i < 16; i++) begin
            move(int'($urandom % N), 8'($urandom), 8'($urandom), 0);
        end

        // Reset in the middle of a long move.
        move(0, 8'h00, 8'h00, 0);
        move(0, 8'hFF, 8'h10, 3);
        #2 rst_n = 1'b0;
        #1 check_reset();
        $display("reset asserted mid-move");
        @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        move(0, 8'h00, 8'h00, 0);
        move(0, 8'h02, 8'h01, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
